// File: rtl/lab2_proc_fetch_unit.sv
// Fetch unit: PC_F, credit-limited imem requests, in-flight PC queue,
// two-entry instruction buffer toward decode, redirect squashing.
//
// Parameters : RESET_VECTOR (PC after reset), MAX_INFLIGHT (credit limit, 2)
// Ports      : clk, reset (sync, active-high)
//              imemreq_val/rdy/addr   - fetch request channel
//              imemresp_val/rdy/data  - in-order instruction responses
//              redirect_val/target    - branch/jump redirect from X
//              inst_val_D/rdy_D, inst_D, pc_D - instruction to decode
// Option     : LAB2_PROC_FETCH_PERF_EN adds num_fetched / num_squashed
module lab2_proc_fetch_unit #(
    parameter logic [31:0] RESET_VECTOR = 32'h00000200,
    parameter int          MAX_INFLIGHT = 2
) (
    input  logic        clk,
    input  logic        reset,
    output logic        imemreq_val,
    input  logic        imemreq_rdy,
    output logic [31:0] imemreq_addr,
    input  logic        imemresp_val,
    output logic        imemresp_rdy,
    input  logic [31:0] imemresp_data,
    input  logic        redirect_val,
    input  logic [31:0] redirect_target,
    output logic        inst_val_D,
    input  logic        inst_rdy_D,
    output logic [31:0] inst_D,
    output logic [31:0] pc_D
`ifdef LAB2_PROC_FETCH_PERF_EN
    ,
    output logic [31:0] num_fetched,
    output logic [31:0] num_squashed
`endif
);

    logic [31:0] r_pc_f;

    logic [31:0] r_pcq [0:1];
    logic        r_pcq_wr;
    logic        r_pcq_rd;
    logic [1:0]  r_pcq_cnt;

    logic [31:0] r_buf_pc   [0:1];
    logic [31:0] r_buf_inst [0:1];
    logic        r_buf_wr;
    logic        r_buf_rd;
    logic [1:0]  r_buf_cnt;

    logic [1:0]  r_drop_cnt;

    logic        w_fire;
    logic        w_resp;
    logic        w_drop;
    logic        w_enq;
    logic        w_deq;
    logic [2:0]  w_occ;
    logic [31:0] w_resp_pc;

    // In-flight requests and buffered instructions share one credit pool,
    // so a response always has a free buffer slot waiting for it.
    assign w_occ = {1'b0, r_pcq_cnt} + {1'b0, r_buf_cnt};

    assign imemreq_val  = !reset && !redirect_val
                        && (w_occ < 3'(MAX_INFLIGHT));
    assign imemreq_addr = r_pc_f;
    assign imemresp_rdy = !reset;

    assign inst_val_D = !reset && !redirect_val && (r_buf_cnt != 2'd0);
    assign inst_D     = r_buf_inst[r_buf_rd];
    assign pc_D       = r_buf_pc[r_buf_rd];

    assign w_fire    = imemreq_val && imemreq_rdy;
    assign w_resp    = imemresp_val && imemresp_rdy
                     && (r_pcq_cnt != 2'd0);
    // Responses belonging to the squashed path: in the redirect cycle
    // itself, or while older requests are still owed a drop.
    assign w_drop    = w_resp && (redirect_val || (r_drop_cnt != 2'd0));
    assign w_enq     = w_resp && !w_drop;
    assign w_deq     = inst_val_D && inst_rdy_D;
    assign w_resp_pc = r_pcq[r_pcq_rd];

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pc_f <= RESET_VECTOR;
        end else if (redirect_val) begin
            r_pc_f <= redirect_target;
        end else if (w_fire) begin
            r_pc_f <= r_pc_f + 32'd4;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_pcq_wr  <= 1'b0;
            r_pcq_rd  <= 1'b0;
            r_pcq_cnt <= 2'd0;
        end else begin
            if (w_fire) begin
                r_pcq_wr <= ~r_pcq_wr;
            end
            if (w_resp) begin
                r_pcq_rd <= ~r_pcq_rd;
            end
            r_pcq_cnt <= r_pcq_cnt + 2'(w_fire) - 2'(w_resp);
        end
    end

    always_ff @(posedge clk) begin
        if (w_fire) begin
            r_pcq[r_pcq_wr] <= r_pc_f;
        end
    end

    always_ff @(posedge clk) begin
        if (reset || redirect_val) begin
            r_buf_wr  <= 1'b0;
            r_buf_rd  <= 1'b0;
            r_buf_cnt <= 2'd0;
        end else begin
            if (w_enq) begin
                r_buf_wr <= ~r_buf_wr;
            end
            if (w_deq) begin
                r_buf_rd <= ~r_buf_rd;
            end
            r_buf_cnt <= r_buf_cnt + 2'(w_enq) - 2'(w_deq);
        end
    end

    always_ff @(posedge clk) begin
        if (w_enq) begin
            r_buf_pc[r_buf_wr]   <= w_resp_pc;
            r_buf_inst[r_buf_wr] <= imemresp_data;
        end
    end

    // No request fires during a redirect, so everything still in the
    // PC queue after this cycle's response belongs to the old path.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_drop_cnt <= 2'd0;
        end else if (redirect_val) begin
            r_drop_cnt <= r_pcq_cnt - 2'(w_resp);
        end else if (w_drop) begin
            r_drop_cnt <= r_drop_cnt - 2'd1;
        end
    end

`ifdef LAB2_PROC_FETCH_PERF_EN
    logic [31:0] r_num_fetched;
    logic [31:0] r_num_squashed;
    logic [31:0] w_flushed;

    assign w_flushed = redirect_val ? 32'(r_buf_cnt) : 32'd0;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_num_fetched  <= 32'd0;
            r_num_squashed <= 32'd0;
        end else begin
            r_num_fetched  <= r_num_fetched + 32'(w_deq);
            r_num_squashed <= r_num_squashed + 32'(w_drop) + w_flushed;
        end
    end

    assign num_fetched  = r_num_fetched;
    assign num_squashed = r_num_squashed;
`endif

endmodule

// File: tb/tb_lab2_proc_fetch_unit.sv
// Testbench for lab2_proc_fetch_unit: directed scenarios plus randomized
// traffic checked each cycle against a queue-based behavioural model.
module tb_lab2_proc_fetch_unit;

    localparam logic [31:0] RV = 32'h00000200;

    logic        clk = 1'b0;
    logic        reset;
    logic        imemreq_val;
    logic        imemreq_rdy;
    logic [31:0] imemreq_addr;
    logic        imemresp_val;
    logic        imemresp_rdy;
    logic [31:0] imemresp_data;
    logic        redirect_val;
    logic [31:0] redirect_target;
    logic        inst_val_D;
    logic        inst_rdy_D;
    logic [31:0] inst_D;
    logic [31:0] pc_D;
`ifdef LAB2_PROC_FETCH_PERF_EN
    logic [31:0] num_fetched;
    logic [31:0] num_squashed;
`endif

    always #5 clk = ~clk;

    lab2_proc_fetch_unit #(.RESET_VECTOR(RV)) dut (
        .clk             (clk),
        .reset           (reset),
        .imemreq_val     (imemreq_val),
        .imemreq_rdy     (imemreq_rdy),
        .imemreq_addr    (imemreq_addr),
        .imemresp_val    (imemresp_val),
        .imemresp_rdy    (imemresp_rdy),
        .imemresp_data   (imemresp_data),
        .redirect_val    (redirect_val),
        .redirect_target (redirect_target),
        .inst_val_D      (inst_val_D),
        .inst_rdy_D      (inst_rdy_D),
        .inst_D          (inst_D),
        .pc_D            (pc_D)
`ifdef LAB2_PROC_FETCH_PERF_EN
        ,
        .num_fetched     (num_fetched),
        .num_squashed    (num_squashed)
`endif
    );

    int n_cmp = 0;
    int n_bad = 0;
    int cyc   = 0;
    int mem_mode = 0;

    // Model: memory-side outstanding addresses, decode-side buffer.
    logic [31:0] m_pc = RV;
    logic [31:0] m_mem [$];
    logic [31:0] m_bpc [$];
    logic [31:0] m_binst [$];
    int          m_drop = 0;
    logic [31:0] m_fetched = 0;
    logic [31:0] m_squashed = 0;
    bit          m_init = 0;

    logic [31:0] fire_log [$];
    int          fire_cyc [$];
    logic [31:0] deliv_log [$];
    int          deliv_cyc [$];

    function automatic logic [31:0] mem_data(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h13579BDF;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)",
                     nm, act, exp, cyc);
        end
    endtask

    task automatic chk1(input string nm, input logic act, input logic exp);
        chk(nm, {31'd0, act}, {31'd0, exp});
    endtask

    // One cycle: called at posedge+1 with inputs already driven.
    task automatic step();
        logic e_rv, e_iv, fire, deq, rsp, rst, rdv;
        logic [31:0] tgt, a;
        bit v;
        imemresp_val  = 1'b0;
        imemresp_data = 32'd0;
        v = 0;
        if (!reset && m_mem.size() > 0) begin
            case (mem_mode)
                0:       v = 1;
                1:       v = 0;
                default: v = ($urandom_range(0, 2) != 0);
            endcase
        end
        if (v) begin
            imemresp_val  = 1'b1;
            imemresp_data = mem_data(m_mem[0]);
        end
        #3;
        e_rv = !reset && !redirect_val && (m_mem.size() + m_bpc.size() < 2);
        e_iv = !reset && !redirect_val && (m_bpc.size() > 0);
        chk1("imemreq_val", imemreq_val, e_rv);
        chk1("imemresp_rdy", imemresp_rdy, !reset);
        chk1("inst_val_D", inst_val_D, e_iv);
        if (e_rv) chk("imemreq_addr", imemreq_addr, m_pc);
        if (e_iv) begin
            chk("inst_D", inst_D, m_binst[0]);
            chk("pc_D", pc_D, m_bpc[0]);
        end
`ifdef LAB2_PROC_FETCH_PERF_EN
        if (m_init) begin
            chk("num_fetched", num_fetched, m_fetched);
            chk("num_squashed", num_squashed, m_squashed);
        end
`endif
        fire = e_rv && imemreq_rdy;
        deq  = e_iv && inst_rdy_D;
        rsp  = imemresp_val;
        rst  = reset;
        rdv  = redirect_val;
        tgt  = redirect_target;
        if (fire) begin
            fire_log.push_back(m_pc);
            fire_cyc.push_back(cyc);
        end
        if (deq) begin
            deliv_log.push_back(m_bpc[0]);
            deliv_cyc.push_back(cyc);
        end
        @(posedge clk);
        #1;
        cyc++;
        if (rst) begin
            m_mem.delete();
            m_bpc.delete();
            m_binst.delete();
            m_pc = RV;
            m_drop = 0;
            m_fetched = 0;
            m_squashed = 0;
            m_init = 1;
        end else begin
            if (deq) begin
                void'(m_bpc.pop_front());
                void'(m_binst.pop_front());
                m_fetched++;
            end
            if (rsp) begin
                a = m_mem.pop_front();
                if (rdv || m_drop > 0) begin
                    m_squashed++;
                    if (!rdv) m_drop--;
                end else begin
                    m_bpc.push_back(a);
                    m_binst.push_back(mem_data(a));
                end
            end
            if (rdv) begin
                m_squashed += 32'(m_bpc.size());
                m_bpc.delete();
                m_binst.delete();
                m_drop = m_mem.size();
                m_pc = tgt;
            end else if (fire) begin
                m_mem.push_back(m_pc);
                m_pc = m_pc + 32'd4;
            end
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic clr_logs();
        fire_log.delete();
        fire_cyc.delete();
        deliv_log.delete();
        deliv_cyc.delete();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        redirect_val = 1'b0;
        run(2);
        reset = 1'b0;
    endtask

    initial begin
        logic [31:0] r;
        reset = 1'b1;
        imemreq_rdy = 1'b0;
        inst_rdy_D = 1'b0;
        redirect_val = 1'b0;
        redirect_target = 32'd0;
        imemresp_val = 1'b0;
        imemresp_data = 32'd0;
        @(posedge clk);
        #1;
        run(3);
        chk1("rst_req_val", imemreq_val, 1'b0);
        chk1("rst_inst_val", inst_val_D, 1'b0);
        chk1("rst_resp_rdy", imemresp_rdy, 1'b0);

        // Streaming after reset
        reset = 1'b0;
        imemreq_rdy = 1'b1;
        inst_rdy_D = 1'b1;
        mem_mode = 0;
        #1;
        chk1("first_req_val", imemreq_val, 1'b1);
        chk("first_req_addr", imemreq_addr, RV);
        clr_logs();
        run(10);
        chk1("t1_nfire", fire_log.size() >= 3, 1'b1);
        chk1("t1_ndeliv", deliv_log.size() >= 2, 1'b1);
        if (fire_log.size() >= 3 && deliv_log.size() >= 2) begin
            chk("t1_fire0", fire_log[0], 32'h200);
            chk("t1_fire1", fire_log[1], 32'h204);
            chk("t1_fire2", fire_log[2], 32'h208);
            chk("t1_deliv0", deliv_log[0], 32'h200);
            chk("t1_deliv1", deliv_log[1], 32'h204);
            chk("t1_lat", 32'(deliv_cyc[0] - fire_cyc[0]), 32'd2);
        end

        // Decode stall fills the credits, then drains in order
        do_reset();
        inst_rdy_D = 1'b0;
        clr_logs();
        run(6);
        chk("t2_nfire", 32'(fire_log.size()), 32'd2);
        chk1("t2_req_held", imemreq_val, 1'b0);
        chk("t2_ndeliv", 32'(deliv_log.size()), 32'd0);
        inst_rdy_D = 1'b1;
        run(3);
        chk1("t2_ndeliv2", deliv_log.size() >= 2, 1'b1);
        if (deliv_log.size() >= 2) begin
            chk("t2_deliv0", deliv_log[0], 32'h200);
            chk("t2_deliv1", deliv_log[1], 32'h204);
        end

        // Redirect with two requests in flight, none returning
        do_reset();
        mem_mode = 1;
        run(3);
        redirect_val = 1'b1;
        redirect_target = 32'h1000;
        step();
        redirect_val = 1'b0;
        mem_mode = 0;
        clr_logs();
        run(8);
        chk1("t3_ndeliv", deliv_log.size() >= 1, 1'b1);
        if (deliv_log.size() >= 1) chk("t3_deliv0", deliv_log[0], 32'h1000);
`ifdef LAB2_PROC_FETCH_PERF_EN
        chk("t3_squashed", num_squashed, 32'd2);
`endif

        // Address wrap
        redirect_val = 1'b1;
        redirect_target = 32'hFFFFFFFC;
        step();
        redirect_val = 1'b0;
        clr_logs();
        run(5);
        chk1("t4_nfire", fire_log.size() >= 2, 1'b1);
        if (fire_log.size() >= 2) begin
            chk("t4_fire0", fire_log[0], 32'hFFFFFFFC);
            chk("t4_fire1", fire_log[1], 32'h00000000);
        end

        // Request-ready toggling
        do_reset();
        clr_logs();
        for (int i = 0; i < 4; i++) begin
            imemreq_rdy = (i % 2 == 0);
            step();
        end
        chk("t5_nfire", 32'(fire_log.size()), 32'd2);
        if (fire_log.size() == 2) begin
            chk("t5_fire0", fire_log[0], 32'h200);
            chk("t5_fire1", fire_log[1], 32'h204);
        end

        // Randomized traffic
        mem_mode = 2;
        for (int i = 0; i < 3000; i++) begin
            reset = ($urandom_range(0, 299) == 0);
            imemreq_rdy = ($urandom_range(0, 3) != 0);
            inst_rdy_D = ($urandom_range(0, 2) != 0);
            redirect_val = ($urandom_range(0, 11) == 0);
            r = $urandom;
            if ($urandom_range(0, 7) == 0) r = 32'hFFFFFFF8;
            redirect_target = {r[31:2], 2'b00};
            step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_bad);
        $finish;
    end

endmodule
